fp_sorter: RTL and testbench
============================

# fp_sorter

Sequential in-place sorter for a small buffer of 13-bit floating-point words (sign, 4-bit exponent, 8-bit fraction). It uses one shared `fp_gt` comparator, which it sequences through a bubble-sort schedule at one comparison per clock. The block sits between a loader (writes the buffer) and a consumer (reads sorted results) in the floating-point prototyping path. It is the first sequential user of `fp_gt`.

## Interface

- `N`, default 4: number of buffer entries; legal range 2..16.
- `AW`, default 2: address width; must satisfy 2^AW >= N.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe for the buffer.
- `wr_addr`  in  AW  write address; values >= N are ignored.
- `din`  in  13  write data {sign, exp[3:0], frac[7:0]}.
- `start`  in  1  request a sort of entries 0..N-1.
- `rd_addr`  in  AW  read address.
- `dout`  out  13  combinational read of entry `rd_addr`; 0 if `rd_addr` >= N.
- `busy`  out  1  high while sorting.
- `done`  out  1  one-cycle tick when a sort completes.

## Operation

- Ordering is the `fp_gt` relation on {sign1,exp1,frac1} vs {sign2,exp2,frac2}:
  - Different signs: the positive operand is greater, so +0 > -0.
  - Both positive: larger {exp,frac} magnitude is greater.
  - Both negative: smaller magnitude is greater.
  - Identical words: `gt` = 0.
- Sort result is ascending: entry 0 holds the smallest value, entry N-1 the largest.
- The sort is stable. A swap happens only when `gt`(mem[j], mem[j+1]) = 1.
- FSM states:
  - IDLE: `busy`=0. `wr_en` writes `din` to mem[`wr_addr`]. `start`=1 loads pass=0, j=0 and goes to SORT. If `wr_en` and `start` are both high, the write commits and the sort starts on the next cycle, so it includes the new data.
  - SORT: `busy`=1. Each cycle:
    - Drive `fp_gt` with mem[j] and mem[j+1].
    - If `gt`=1, write mem[j] <= mem[j+1] and mem[j+1] <= mem[j] in the same edge.
    - If j = N-2-pass: j <= 0 and pass <= pass+1. Otherwise j <= j+1.
    - After the compare with pass = N-2 and j = 0, go to DONE.
  - DONE: `busy`=0, `done`=1 for exactly one cycle, then unconditionally go to IDLE. `wr_en` and `start` are ignored in DONE.
- While in SORT, `wr_en` and `start` are ignored: no write, no restart.
- Early exit on a swap-free pass is not performed. Cycle count is data-independent.
- Counters: pass and j are AW bits wide. No wrap-around occurs for legal N.

## Timing

- Reset (synchronous):
  - FSM goes to IDLE; `busy`=0, `done`=0; pass=0, j=0.
  - Buffer contents are not altered by reset.
- Reset asserted in SORT aborts the sort. The buffer keeps whatever partial permutation exists at that edge, and no `done` tick is produced.
- `start` sampled high at edge k (in IDLE):
  - `busy`=1 for cycles k+1 .. k+N(N-1)/2, which is 6 cycles for N=4.
  - `done`=1 in the following cycle, with `busy`=0.
  - Back in IDLE one cycle after that.
- `dout` is combinational and valid in IDLE and DONE. During SORT its value is unspecified.
- The comparator path is combinational, mem -> `fp_gt` -> swap write, and must close in one clock.

## Test plan

- Reset: assert `reset` 2 cycles -> `busy`=0 and `done`=0, both held until `start`.
- Mixed sort, N=4: load {0,3,87}, {0,2,100}, {1,5,100}, {0,2,50}, pulse `start`:
  - `busy` is high exactly 6 cycles, then `done` pulses once.
  - Readback of entries 0..3 is {1,5,100}, {0,2,50}, {0,2,100}, {0,3,87}.
- Pre-sorted and all-negative input:
  - Load {0,1,9}, {0,2,87}, {0,2,100}, {0,5,100}, sort -> order unchanged, still 6 busy cycles.
  - Load {1,1,9}, {1,2,87}, {1,3,100}, {1,5,100}, sort -> {1,5,100}, {1,3,100}, {1,2,87}, {1,1,9}.
- Ties and signed zero:
  - Load {0,0,0}, {1,0,0}, {0,2,87}, {0,2,87}, sort -> {1,0,0}, {0,0,0}, {0,2,87}, {0,2,87}.
  - Duplicates must not be swapped; instrument the swap count and expect 1.
- Ignored inputs while busy:
  - During SORT, pulse `start` and write {0,15,255} to address 0.
  - Expect exactly one `done`, 6 busy cycles, and a result identical to the mixed-sort case.
- Reset mid-sort:
  - Assert `reset` in the 3rd busy cycle -> `busy`=0 next cycle and no `done`.
  - Reload the mixed-sort data, `start` again -> the correct sorted result and one `done`.

Source files
------------

// File: rtl/fp_sorter_if.sv
// Loader/consumer-side bus of fp_sorter: buffer write port, sort request, read port and status.
interface fp_sorter_if #(
  parameter int unsigned AW = 2
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [12:0]   din;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [12:0]   dout;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, din, start, rd_addr,
    input  dout, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, din, start, rd_addr,
    output dout, busy, done
  );
endinterface

// File: rtl/fp_sorter.sv
// In-place ascending bubble sort of N 13-bit floats {sign, exp[3:0], frac[7:0]},
// one fp_gt comparison per clock, data-independent cycle count.

// Strict greater-than on sign-magnitude floats; identical words compare as not greater.
module fp_gt (
  input  logic [12:0] a,
  input  logic [12:0] b,
  output logic        gt
);
  always_comb begin
    if (a[12] != b[12]) begin
      gt = b[12];
    end else if (!a[12]) begin
      gt = (a[11:0] > b[11:0]);
    end else begin
      gt = (a[11:0] < b[11:0]);
    end
  end
endmodule

module fp_sorter #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  fp_sorter_if.slave  bus
);
  localparam int unsigned DW = 13;
  localparam logic [AW:0]   N_EXT     = (AW+1)'(N);
  localparam logic [AW-1:0] LAST_PASS = AW'(N - 2);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] pass, pass_d;
  logic [AW-1:0] j, j_d, j1;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] a_c, b_c;
  logic          gt_c, swap_c;

  assign j1  = j + AW'(1);
  assign a_c = mem[j];
  assign b_c = mem[j1];

  fp_gt u_gt (.a(a_c), .b(b_c), .gt(gt_c));

  // Next-state, counter advance and swap decision
  always_comb begin
    state_d = state;
    pass_d  = pass;
    j_d     = j;
    swap_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = SORT;
          pass_d  = '0;
          j_d     = '0;
        end
      end
      SORT: begin
        swap_c = gt_c;
        if (j == LAST_PASS - pass) begin
          j_d    = '0;
          pass_d = pass + AW'(1);
          if (pass == LAST_PASS) begin
            state_d = DONE;
          end
        end else begin
          j_d = j + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pass     <= '0;
      j        <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_d;
      pass     <= pass_d;
      j        <= j_d;
      bus.busy <= (state_d == SORT);
      bus.done <= (state_d == DONE);
    end
  end

  // Buffer is never cleared by reset; a reset edge also suppresses any pending swap
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && bus.wr_en && ({1'b0, bus.wr_addr} < N_EXT)) begin
        mem[bus.wr_addr] <= bus.din;
      end else if (swap_c) begin
        mem[j]  <= b_c;
        mem[j1] <= a_c;
      end
    end
  end

  assign bus.dout = ({1'b0, bus.rd_addr} < N_EXT) ? mem[bus.rd_addr] : '0;
endmodule

// File: tb/tb_fp_sorter.sv
// Directed self-checking bench for fp_sorter (N=4): ordering, timing, ignored inputs, reset abort.
module tb_fp_sorter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fp_sorter_if #(.AW(2)) bus ();

  fp_sorter #(.N(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] fp(input logic s, input int e, input int f);
    return {s, 4'(e), 8'(f)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [12:0] w0, input logic [12:0] w1,
                      input logic [12:0] w2, input logic [12:0] w3);
    logic [12:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.din     = w[i];
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic readback(input string tag, input logic [12:0] e0, input logic [12:0] e1,
                          input logic [12:0] e2, input logic [12:0] e3);
    logic [12:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      chk($sformatf("%s_entry%0d", tag, i), 32'(bus.dout), 32'(e[i]));
    end
  endtask

  // Pulse start, then watch a fixed 14-cycle window; optionally poke start/write mid-sort
  task automatic run_sort(input string tag, input bit poke, output int scnt);
    int bcnt, dcnt, ovl;
    bcnt = 0; dcnt = 0; ovl = 0; scnt = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (bus.busy) bcnt++;
      if (bus.done) dcnt++;
      if (bus.done && bus.busy) ovl++;
      if (dut.swap_c) scnt++;
      if (poke && c == 2) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd0;
        bus.din     = fp(1'b0, 15, 255);
      end else begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd6);
    chk({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
    chk({tag, "_done_busy_overlap"}, 32'(ovl), 32'd0);
  endtask

  initial begin
    int sw;
    int dseen;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.din = '0; bus.start = 1'b0; bus.rd_addr = '0;

    // Reset held two cycles, then status stays low while idle
    step();
    step();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);

    // Mixed signs
    load(fp(0,3,87), fp(0,2,100), fp(1,5,100), fp(0,2,50));
    run_sort("mixed", 1'b0, sw);
    readback("mixed", fp(1,5,100), fp(0,2,50), fp(0,2,100), fp(0,3,87));

    // Already sorted: no swaps, same cycle count
    load(fp(0,1,9), fp(0,2,87), fp(0,2,100), fp(0,5,100));
    run_sort("presorted", 1'b0, sw);
    chk("presorted_swaps", 32'(sw), 32'd0);
    readback("presorted", fp(0,1,9), fp(0,2,87), fp(0,2,100), fp(0,5,100));

    // All negative, ascending magnitude becomes descending magnitude
    load(fp(1,1,9), fp(1,2,87), fp(1,3,100), fp(1,5,100));
    run_sort("negative", 1'b0, sw);
    chk("negative_swaps", 32'(sw), 32'd6);
    readback("negative", fp(1,5,100), fp(1,3,100), fp(1,2,87), fp(1,1,9));

    // Signed zero and duplicates: only the +0/-0 pair swaps
    load(fp(0,0,0), fp(1,0,0), fp(0,2,87), fp(0,2,87));
    run_sort("ties", 1'b0, sw);
    chk("ties_swaps", 32'(sw), 32'd1);
    readback("ties", fp(1,0,0), fp(0,0,0), fp(0,2,87), fp(0,2,87));

    // start and write during SORT are ignored
    load(fp(0,3,87), fp(0,2,100), fp(1,5,100), fp(0,2,50));
    run_sort("poke", 1'b1, sw);
    readback("poke", fp(1,5,100), fp(0,2,50), fp(0,2,100), fp(0,3,87));

    // Reset in the 3rd busy cycle aborts with no done
    load(fp(0,3,87), fp(0,2,100), fp(1,5,100), fp(0,2,50));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("abort_busy_c1", 32'(bus.busy), 32'd1);
    step();
    step();
    chk("abort_busy_c3", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy_after", 32'(bus.busy), 32'd0);
    chk("abort_done_after", 32'(bus.done), 32'd0);
    dseen = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done || bus.busy) dseen++;
      step();
    end
    chk("abort_no_activity", 32'(dseen), 32'd0);

    load(fp(0,3,87), fp(0,2,100), fp(1,5,100), fp(0,2,50));
    run_sort("resort", 1'b0, sw);
    readback("resort", fp(1,5,100), fp(0,2,50), fp(0,2,100), fp(0,3,87));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
